// File: rtl/prl_hr_receive.sv
// USB-PD protocol-layer Hard Reset receive handler: qualifies PHY Hard Reset
// reports, sequences the protocol reset and policy-engine hand-off, raises ALERT.
module prl_hr_receive #(
    parameter int TIMEOUT_CYCLES = 200,
    parameter int TMR_W          = 8
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        PHY_HardReset,
    input  logic [6:0]  RECEIVE_DETECT,
    input  logic        PE_HardResetComplete,
    input  logic [15:0] ALERT_clear,
    output logic [15:0] ALERT,
    output logic        PRL_Reset,
    output logic        PE_HardResetInd,
    output logic        RX_Block,
    output logic        HR_Timeout,
    output logic [3:0]  HR_Count
);

    typedef enum logic [4:0] {
        PRL_HR_IDLE        = 5'b00001,
        PRL_HR_RESET_LAYER = 5'b00010,
        PRL_HR_INDICATE    = 5'b00100,
        PRL_HR_WAIT_PE     = 5'b01000,
        PRL_HR_PE_COMPLETE = 5'b10000
    } state_t;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};

    state_t           state_r;
    state_t           state_next_s;
    logic [TMR_W-1:0] timer_r;
    logic             alert_hr_r;
    logic             qualified_s;
    logic             timeout_s;
    logic             unused_s;

    assign qualified_s = PHY_HardReset & RECEIVE_DETECT[5];
    assign unused_s    = ^{RECEIVE_DETECT[6], RECEIVE_DETECT[4:0],
                           ALERT_clear[15:4], ALERT_clear[2:0]};
    assign ALERT       = {12'b0, alert_hr_r, 3'b0};

    // Next-state selection; a new qualified Hard Reset outranks complete and timeout.
    always_comb begin
        state_next_s = PRL_HR_IDLE;
        timeout_s    = 1'b0;
        case (state_r)
            PRL_HR_IDLE: begin
                if (qualified_s) begin
                    state_next_s = PRL_HR_RESET_LAYER;
                end else begin
                    state_next_s = PRL_HR_IDLE;
                end
            end
            PRL_HR_RESET_LAYER: state_next_s = PRL_HR_INDICATE;
            PRL_HR_INDICATE:    state_next_s = PRL_HR_WAIT_PE;
            PRL_HR_WAIT_PE: begin
                if (qualified_s) begin
                    state_next_s = PRL_HR_RESET_LAYER;
                end else if (PE_HardResetComplete) begin
                    state_next_s = PRL_HR_PE_COMPLETE;
                end else if (timer_r == TMR_LAST) begin
                    state_next_s = PRL_HR_PE_COMPLETE;
                    timeout_s    = 1'b1;
                end else begin
                    state_next_s = PRL_HR_WAIT_PE;
                end
            end
            PRL_HR_PE_COMPLETE: state_next_s = PRL_HR_IDLE;
            default:            state_next_s = PRL_HR_IDLE;
        endcase
    end

    // State register and outputs; outputs are registered from the next state so
    // they are high exactly while the FSM occupies the corresponding state.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_r         <= PRL_HR_IDLE;
            timer_r         <= {TMR_W{1'b0}};
            alert_hr_r      <= 1'b0;
            PRL_Reset       <= 1'b0;
            PE_HardResetInd <= 1'b0;
            RX_Block        <= 1'b0;
            HR_Timeout      <= 1'b0;
            HR_Count        <= 4'd0;
        end else begin
            state_r         <= state_next_s;
            PRL_Reset       <= (state_next_s == PRL_HR_RESET_LAYER);
            PE_HardResetInd <= (state_next_s == PRL_HR_INDICATE);
            RX_Block        <= (state_next_s != PRL_HR_IDLE);

            if (state_next_s == PRL_HR_RESET_LAYER && HR_Count != 4'd15) begin
                HR_Count <= HR_Count + 4'd1;
            end

            if (state_next_s == PRL_HR_RESET_LAYER) begin
                HR_Timeout <= 1'b0;
            end else if (timeout_s) begin
                HR_Timeout <= 1'b1;
            end

            if (state_next_s == PRL_HR_INDICATE) begin
                timer_r <= {TMR_W{1'b0}};
            end else if (state_r == PRL_HR_WAIT_PE && timer_r != TMR_MAX) begin
                timer_r <= timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
            end

            // Set covers the whole INDICATE cycle so a coincident clear loses.
            if (state_next_s == PRL_HR_INDICATE || state_r == PRL_HR_INDICATE) begin
                alert_hr_r <= 1'b1;
            end else if (ALERT_clear[3]) begin
                alert_hr_r <= 1'b0;
            end
        end
    end

endmodule
